// File: rtl/filt_cfir_comp_pkg.sv
// Shared definitions for the serial-MAC CIC compensation FIR: state codes,
// accumulator sizing and coefficient extraction from the packed parameter.
package filt_cfir_comp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Upper bound on the packed coefficient vector handled by coeff_at.
  localparam int COEF_VEC_MAX = 1024;

  // Growth of log2(taps) bits keeps the sum of all products free of overflow.
  function automatic int acc_width(input int prod_w, input int nr_taps);
    return prod_w + $clog2(nr_taps);
  endfunction

  // Tap k lives at bits [(k+1)*w-1 -: w]; result is sign-extended to 32 bits.
  function automatic logic signed [31:0] coeff_at(input logic [COEF_VEC_MAX-1:0] vec,
                                                  input int k, input int w);
    logic signed [31:0] r;
    int idx;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      idx = k * w + ((b < w) ? b : (w - 1));
      if (idx < COEF_VEC_MAX) r[b] = vec[idx[9:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/filt_cfir_comp_round_sat.sv
// Combinational requantiser: round-half-up by a right shift, then clamp to the
// signed output range without wrap-around.
module filt_cfir_comp_round_sat #(
  parameter int gp_in_width  = 27,
  parameter int gp_shift     = 14,
  parameter int gp_out_width = 10
) (
  input  logic signed [gp_in_width-1:0]  i_data,
  output logic signed [gp_out_width-1:0] o_data
);

  // One guard bit so the rounding offset can never overflow the input range.
  localparam int EXT_W = gp_in_width + 1;

  localparam logic signed [EXT_W-1:0] RND_OFS =
    (gp_shift > 0) ? (EXT_W'(1) << ((gp_shift > 0) ? (gp_shift - 1) : 0)) : '0;
  localparam logic signed [EXT_W-1:0] MAX_V =
    {{(EXT_W - gp_out_width + 1){1'b0}}, {(gp_out_width - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [gp_out_width-1:0] rnd_sat(
      input logic signed [gp_in_width-1:0] v);
    logic signed [EXT_W-1:0] t;
    t = EXT_W'(v) + RND_OFS;
    t = t >>> gp_shift;
    if (t > MAX_V) return MAX_V[gp_out_width-1:0];
    if (t < MIN_V) return MIN_V[gp_out_width-1:0];
    return t[gp_out_width-1:0];
  endfunction

  assign o_data = rnd_sat(i_data);

endmodule

// File: rtl/filt_cfir_comp.sv
// CIC compensation FIR with one time-shared multiplier; a new sample starts an
// N-tap MAC sweep whose rounded, saturated result is flagged by a valid pulse.
module filt_cfir_comp
  import filt_cfir_comp_pkg::*;
#(
  parameter int gp_inp_width   = 8,
  parameter int gp_oup_width   = gp_inp_width + 2,
  parameter int gp_coeff_width = 16,
  parameter int gp_coeff_frac  = 14,
  parameter int gp_nr_taps     = 5,
  parameter logic [gp_nr_taps*gp_coeff_width-1:0] gp_coeffs =
    {-16'sd1024, 16'sd2048, 16'sd14336, 16'sd2048, -16'sd1024}
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_ena,
  input  logic signed [gp_inp_width-1:0] i_data,
  output logic signed [gp_oup_width-1:0] o_data,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_overrun
);

  localparam int P_W   = gp_inp_width + gp_coeff_width;
  localparam int A_W   = acc_width(P_W, gp_nr_taps);
  localparam int CNT_W = $clog2(gp_nr_taps);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(gp_nr_taps - 1);

  logic [1:0]                     state;
  logic [CNT_W-1:0]               tap_cnt;
  logic signed [gp_inp_width-1:0] x_dl [gp_nr_taps];
  logic signed [gp_coeff_width-1:0] coef [gp_nr_taps];
  logic signed [P_W-1:0]          mult_p0;
  logic signed [P_W-1:0]          prod_p0;
  logic signed [A_W-1:0]          acc_p1;
  logic signed [gp_oup_width-1:0] rs_out;

  for (genvar g = 0; g < gp_nr_taps; g++) begin : g_coef
    assign coef[g] = gp_coeff_width'(coeff_at(COEF_VEC_MAX'(gp_coeffs), g, gp_coeff_width));
  end

  // Stage p0: tap select and product
  assign mult_p0 = P_W'(x_dl[tap_cnt]) * P_W'(coef[tap_cnt]);

  assign o_busy = (state != ST_IDLE);

  // Stage p1: accumulate lags the multiplier by one edge, hence the FLUSH step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      tap_cnt   <= '0;
      prod_p0   <= '0;
      acc_p1    <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      for (int i = 0; i < gp_nr_taps; i++) x_dl[i] <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_ena && (state != ST_IDLE)) o_overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_ena) begin
            x_dl[0] <= i_data;
            for (int i = gp_nr_taps - 1; i > 0; i--) x_dl[i] <= x_dl[i-1];
            acc_p1  <= '0;
            tap_cnt <= '0;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          prod_p0 <= mult_p0;
          if (tap_cnt != '0) acc_p1 <= acc_p1 + A_W'(prod_p0);
          if (tap_cnt == LAST_TAP) state <= ST_FLUSH;
          else tap_cnt <= tap_cnt + CNT_W'(1);
        end
        ST_FLUSH: begin
          acc_p1 <= acc_p1 + A_W'(prod_p0);
          state  <= ST_OUT;
        end
        ST_OUT: begin
          o_data  <= rs_out;
          o_valid <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Requantise the full-precision sum to the output width
  filt_cfir_comp_round_sat #(
    .gp_in_width (A_W),
    .gp_shift    (gp_coeff_frac),
    .gp_out_width(gp_oup_width)
  ) u_round_sat (
    .i_data(acc_p1),
    .o_data(rs_out)
  );

endmodule

// File: tb/tb_filt_cfir_comp.sv
// Bench for filt_cfir_comp: table vectors, overrun/reset sequences and random
// samples checked against an arithmetic FIR model, on 10- and 8-bit outputs.
module tb_filt_cfir_comp;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic signed [7:0] din;
  logic signed [9:0] o_data10;
  logic signed [7:0] o_data8;
  logic              valid10, valid8, busy10, busy8, ovr10, ovr8;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;

  int hist [5];
  int coef_h [5] = '{-1024, 2048, 14336, 2048, -1024};

  typedef struct {
    logic signed [7:0] din;
    int                e10;
    int                e8;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  filt_cfir_comp dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din),
    .o_data(o_data10), .o_valid(valid10), .o_busy(busy10), .o_overrun(ovr10)
  );

  filt_cfir_comp #(.gp_oup_width(8)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din),
    .o_data(o_data8), .o_valid(valid8), .o_busy(busy8), .o_overrun(ovr8)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) hist[k] = 0;
  endtask

  task automatic model_push(input int s);
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
  endtask

  // Exact FIR sum, then floor((sum + 2^13) / 2^14).
  function automatic longint model_round();
    longint sum = 0;
    for (int k = 0; k < 5; k++) sum += longint'(hist[k]) * longint'(coef_h[k]);
    return (sum + 64'sd8192) >>> 14;
  endfunction

  function automatic longint clamp(input longint v, input int w);
    longint hi = (64'sd1 <<< (w - 1)) - 1;
    longint lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic add_vec(input logic signed [7:0] d, input int e10, input int e8);
    vec_t v;
    v.din = d; v.e10 = e10; v.e8 = e8;
    tbl.push_back(v);
  endtask

  // Entered and left at a negedge; on return the bench sits in the o_valid cycle.
  task automatic apply(input logic signed [7:0] s, input longint e10, input longint e8);
    int lat = 0;
    ena = 1'b1; din = s;
    @(negedge clk);
    ena = 1'b0; din = 8'($urandom);
    while (!valid10 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 7);
    check("data10", o_data10, e10);
    check("data8", o_data8, e8);
    check("valid8_aligned", valid8, 1);
    check("busy_low_at_valid", busy10, 0);
    check("overrun_flag", ovr10, exp_ovr);
  endtask

  task automatic apply_model(input logic signed [7:0] s);
    longint r;
    model_push(int'(s));
    r = model_round();
    apply(s, clamp(r, 10), clamp(r, 8));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_ovr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; ena = 1'b0; din = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_data", o_data10, 0);
    check("rst_valid", valid10, 0);
    check("rst_busy", busy10, 0);
    check("rst_overrun", ovr10, 0);
    rst = 1'b0;
    @(negedge clk);

    // Impulse, DC +127, DC -128 and the saturating transitions between them.
    add_vec(100, -6, -6);  add_vec(0, 13, 13);   add_vec(0, 88, 88);
    add_vec(0, 13, 13);    add_vec(0, -6, -6);   add_vec(0, 0, 0);
    add_vec(127, -8, -8);  add_vec(127, 8, 8);   add_vec(127, 119, 119);
    add_vec(127, 135, 127); add_vec(127, 127, 127); add_vec(127, 127, 127);
    add_vec(-128, 143, 127); add_vec(-128, 111, 111); add_vec(-128, -112, -112);
    add_vec(-128, -144, -128); add_vec(-128, -128, -128); add_vec(-128, -128, -128);
    add_vec(127, -144, -128);
    foreach (tbl[i]) begin
      model_push(int'(tbl[i].din));
      apply(tbl[i].din, tbl[i].e10, tbl[i].e8);
    end

    // Overrun: second strobe two edges after the first is dropped.
    @(negedge clk);
    do_reset();
    check("ovr_cleared_by_reset", ovr10, 0);
    ena = 1'b1; din = 8'sd80;
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1; din = 8'sd50;
    @(negedge clk);
    ena = 1'b0; din = '0;
    check("overrun_set", ovr10, 1);
    check("overrun_set_8", ovr8, 1);
    check("busy_during_mac", busy10, 1);
    seen = 2;
    while (!valid10 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    model_push(80);
    check("ovr_latency", seen, 7);
    check("ovr_single_response", o_data10, clamp(model_round(), 10));
    exp_ovr = 1;
    for (int i = 0; i < 5; i++) apply_model(8'sd0);

    // Reset at E0+3 discards the sample in flight.
    @(negedge clk);
    do_reset();
    ena = 1'b1; din = 8'sd100;
    @(negedge clk);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", o_data10, 0);
    check("midrst_valid", valid10, 0);
    check("midrst_busy", busy10, 0);
    check("midrst_overrun", ovr10, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid10) seen++;
    end
    check("midrst_no_valid", seen, 0);
    model_clear();
    apply_model(8'sd100);
    for (int i = 0; i < 5; i++) apply_model(8'sd0);

    // Random samples with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      apply_model(8'($urandom_range(0, 255)));
      @(negedge clk);
      check("valid_one_cycle", valid10, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("no_overrun_final", ovr10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
